irq_ack_decoder: RTL

//  Downstream end of the LC-3 interrupt priority-encoder path. Accepts an encoded

---
 rtl/irq_ack_decoder_if.sv | 19 +
 rtl/irq_ack_decoder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/irq_ack_decoder_if.sv
// +----------------------------------------------------------------------------+
// | irq_ack_decoder_if : encoded-request valid/ready handshake                 |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface irq_ack_decoder_if #(
  parameter int W = 3
);
  logic         enc_valid;
  logic [W-1:0] enc_idx;
  logic [2:0]   enc_pri;
  logic         enc_ready;

  modport master (output enc_valid, output enc_idx, output enc_pri, input  enc_ready);
  modport slave  (input  enc_valid, input  enc_idx, input  enc_pri, output enc_ready);
endinterface

`default_nettype wire

// File: rtl/irq_ack_decoder.sv
// +----------------------------------------------------------------------------+
// | irq_ack_decoder : decodes encoded IRQ into one-hot ack, tracks nesting     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module irq_ack_decoder #(
  parameter int N     = 8,
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  irq_ack_decoder_if.slave    enc,
  input  wire logic           eoi,
  output logic [N-1:0]        ack,
  output logic [N-1:0]        in_service,
  output logic [2:0]          cur_pri,
  output logic                nest_full,
  output logic                nest_empty,
  output logic                err
);

  localparam int             SPW     = $clog2(DEPTH + 1);
  localparam logic [W:0]     N_EXT   = (W + 1)'(N);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [SPW-1:0] r_sp;
  logic [2:0]     r_stk_pri [DEPTH];
  logic [W-1:0]   r_stk_idx [DEPTH];
  logic [W-1:0]   r_ack_idx;
  logic [N-1:0]   r_in_service;
  logic [2:0]     r_cur_pri;
  logic           r_err;

  logic           w_ready;
  logic           w_accept;
  logic           w_bad_idx;
  logic           w_push;
  logic           w_pop;
  logic [2:0]     w_top_pri;
  logic [W-1:0]   w_top_idx;

  assign nest_full  = (r_sp == SP_FULL);
  assign nest_empty = (r_sp == '0);
  assign in_service = r_in_service;
  assign cur_pri    = r_cur_pri;
  assign err        = r_err;

  // EOI blocks acceptance so push and pop never coincide.
  assign w_ready       = (r_state == IDLE) && !nest_full && !eoi && (enc.enc_pri > r_cur_pri);
  assign enc.enc_ready = w_ready;
  assign w_accept      = enc.enc_valid && w_ready;
  assign w_bad_idx     = ({1'b0, enc.enc_idx} >= N_EXT);
  assign w_push        = w_accept && !w_bad_idx;
  assign w_pop         = eoi && !nest_empty;

  always_comb begin
    w_top_pri = '0;
    w_top_idx = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (r_sp == SPW'(e + 1)) begin
        w_top_pri = r_stk_pri[e];
        w_top_idx = r_stk_idx[e];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ack         = '0;
    case (r_state)
      IDLE: if (w_push) w_state_nxt = ACK;
      ACK: begin
        w_state_nxt = IDLE;
        for (int i = 0; i < N; i++) begin
          if (r_ack_idx == W'(i)) ack[i] = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sp         <= '0;
      r_ack_idx    <= '0;
      r_in_service <= '0;
      r_cur_pri    <= '0;
      r_err        <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        r_stk_pri[e] <= '0;
        r_stk_idx[e] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_err   <= (w_accept && w_bad_idx) || (eoi && nest_empty);
      if (w_pop) begin
        r_sp      <= r_sp - 1'b1;
        r_cur_pri <= w_top_pri;
        for (int i = 0; i < N; i++) begin
          if (w_top_idx == W'(i)) r_in_service[i] <= 1'b0;
        end
      end else if (w_push) begin
        // Save the interrupted level so RTI can restore it.
        for (int e = 0; e < DEPTH; e++) begin
          if (r_sp == SPW'(e)) begin
            r_stk_pri[e] <= r_cur_pri;
            r_stk_idx[e] <= enc.enc_idx;
          end
        end
        r_sp      <= r_sp + 1'b1;
        r_cur_pri <= enc.enc_pri;
        r_ack_idx <= enc.enc_idx;
        for (int i = 0; i < N; i++) begin
          if (enc.enc_idx == W'(i)) r_in_service[i] <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
